mac_lane_array: RTL

Parametrised multi-lane multiply-accumulate engine for the matrix-multiply datapath. Each of LANES lanes forms a K-term dot product of DW-bit operand streams. The array supports a runtime signed/unsigned mode, valid/ready handshakes on both sides, and a one-deep output holding register. It sits between the operand SRAM readers and the result write-back, and replaces the single-lane, counter-cleared accumulator.

---
 rtl/mac_lane_array.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mac_lane_array.sv
// mac_lane_array
// Multi-lane multiply-accumulate engine. Every lane builds a K-beat dot
// product of its A/B operand streams. Products are registered in stage P,
// then folded into the lane accumulator in stage A. The finished sum lands
// in a one-deep output holding register.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active low
//   in_valid     operand beat valid
//   in_ready     beat accepted when in_valid && in_ready
//   a_data       lane i operand A at [i*DW +: DW]
//   b_data       lane i operand B, same packing
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled on beat 0)
//   clr          synchronous flush of the vector in progress (held result kept)
//   out_valid    result valid
//   out_ready    result consumed when out_valid && out_ready
//   out_data     lane i sum at [i*ACCW +: ACCW]
//   beat_cnt     beats accepted so far in the current vector
module mac_lane_array #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int K     = 32,
    parameter int ACCW  = 2*DW + $clog2(K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      a_data,
    input  logic [LANES*DW-1:0]      b_data,
    input  logic                     signed_mode,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACCW-1:0]    out_data,
    output logic [$clog2(K)-1:0]     beat_cnt
);

    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST_CNT = CW'(K-1);

    logic          run_reg;
    logic          mode_reg;
    logic [CW-1:0] cnt_reg;
    logic          p_valid_reg;
    logic          p_first_reg;
    logic          p_last_reg;
    logic          out_valid_reg;

    logic stall;
    logic accept;
    logic beat_first;
    logic beat_last;
    logic mode_eff;
    logic a_step;
    logic complete;
    logic out_take;

    // A held result that nobody takes freezes both pipeline stages, so the
    // input must stop as well. run_reg keeps in_ready low until the first
    // edge after reset is released.
    assign stall      = out_valid_reg && !out_ready;
    assign in_ready   = rst && run_reg && !stall && !clr;
    assign accept     = in_valid && in_ready;
    assign beat_first = (cnt_reg == '0);
    assign beat_last  = (cnt_reg == LAST_CNT);
    // Beat 0 uses the live mode pin; later beats use the copy latched on beat 0.
    assign mode_eff   = beat_first ? signed_mode : mode_reg;
    assign a_step     = p_valid_reg && !stall && !clr;
    assign complete   = a_step && p_last_reg;
    assign out_take   = out_valid_reg && out_ready;

    assign out_valid  = out_valid_reg;
    assign beat_cnt   = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_reg       <= 1'b0;
            mode_reg      <= 1'b0;
            cnt_reg       <= '0;
            p_valid_reg   <= 1'b0;
            p_first_reg   <= 1'b0;
            p_last_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;

            if (clr) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= beat_last ? '0 : cnt_reg + CW'(1);
            end

            if (accept && beat_first) begin
                mode_reg <= signed_mode;
            end

            if (clr) begin
                p_valid_reg <= 1'b0;
            end else if (!stall) begin
                p_valid_reg <= accept;
                p_first_reg <= beat_first;
                p_last_reg  <= beat_last;
            end

            // A completing vector wins over a consuming handshake on the same
            // edge, so the new result replaces the old one with no bubble.
            if (complete) begin
                out_valid_reg <= 1'b1;
            end else if (out_take) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0]        a_l;
            logic [DW-1:0]        b_l;
            logic signed [DW:0]   a_x;
            logic signed [DW:0]   b_x;
            logic signed [2*DW:0] prod_w;
            logic [ACCW-1:0]      prod_ext;
            logic [ACCW-1:0]      sum;
            logic [ACCW-1:0]      p_prod_reg;
            logic [ACCW-1:0]      acc_reg;
            logic [ACCW-1:0]      out_reg;

            assign a_l = a_data[gi*DW +: DW];
            assign b_l = b_data[gi*DW +: DW];

            // One extra operand bit turns both modes into a single signed
            // multiply: the top bit copies the sign only in signed mode.
            assign a_x      = {mode_eff & a_l[DW-1], a_l};
            assign b_x      = {mode_eff & b_l[DW-1], b_l};
            assign prod_w   = (2*DW+1)'(a_x) * (2*DW+1)'(b_x);
            assign prod_ext = ACCW'(prod_w);

            // The first beat starts from zero instead of the accumulator, so
            // back-to-back vectors need no clearing cycle.
            assign sum = (p_first_reg ? '0 : acc_reg) + p_prod_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    p_prod_reg <= '0;
                    acc_reg    <= '0;
                    out_reg    <= '0;
                end else begin
                    if (!stall && !clr) begin
                        p_prod_reg <= prod_ext;
                    end
                    if (clr) begin
                        acc_reg <= '0;
                    end else if (a_step) begin
                        acc_reg <= p_last_reg ? '0 : sum;
                    end
                    if (complete) begin
                        out_reg <= sum;
                    end
                end
            end

            assign out_data[gi*ACCW +: ACCW] = out_reg;
        end
    endgenerate

endmodule
